// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants
package pipe_pkg;
  localparam int XLEN = 32;
  localparam int REG_IDX_W = 5;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/fetch_stage_sat_counter.sv
// sat_counter: saturating event counter that sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    count <= !rst_n ? '0 : (inc && !(&count)) ? count + W'(1) : count;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection and IF/ID pipeline register
module fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic [XLEN-1:0]      imem_addr,
  input  logic [XLEN-1:0]      imem_rdata,
  output logic [XLEN-1:0]      if_id_pc,
  output logic [XLEN-1:0]      if_id_instr,
  output logic                 if_id_valid,
  output logic [REG_IDX_W-1:0] if_id_Rs,
  output logic [REG_IDX_W-1:0] if_id_Rt,
  output logic [CNT_W-1:0]     stall_count,
  output logic [CNT_W-1:0]     flush_count
);
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] target;
  logic            stall_inc;
  assign target    = redirect_pc & ~XLEN'(3);
  assign stall_inc = stall && !redirect_valid;
  assign imem_addr = pc;
  assign if_id_Rs  = if_id_valid ? if_id_instr[RS1_LSB +: REG_IDX_W] : '0;
  assign if_id_Rt  = if_id_valid ? if_id_instr[RS2_LSB +: REG_IDX_W] : '0;
  always_ff @(posedge clk) begin
    if (!rst_n || redirect_valid) begin
      pc          <= !rst_n ? RESET_PC : target;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc          <= pc + XLEN'(4);
      if_id_instr <= imem_rdata;
      if_id_pc    <= pc;
      if_id_valid <= 1'b1;
    end
  end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (stall_inc),
    .count(stall_count)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (redirect_valid),
    .count(flush_count)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with 4-bit counters
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_rdata, if_id_pc, if_id_instr;
  logic        if_id_valid;
  logic [4:0]  if_id_Rs, if_id_Rt;
  logic [3:0]  stall_count, flush_count;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] ifpc;
    logic        v;
    logic [3:0]  sc;
    logic [3:0]  fc;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  assign imem_rdata = imem_addr * 32'h0001_0001;
  fetch_stage #(.RESET_PC(32'h0), .CNT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .if_id_Rs      (if_id_Rs),
    .if_id_Rt      (if_id_Rt),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h want %h (t=%0t)", n, a, e, $time);
    end
  endtask
  task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                      input logic [31:0] ea, input logic [31:0] ep, input logic ev,
                      input logic [3:0] esc, input logic [3:0] efc);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    stall = s;
    redirect_valid = rv;
    redirect_pc = rpc;
    e.addr = ea;
    e.ifpc = ep;
    e.v = ev;
    e.sc = esc;
    e.fc = efc;
    q.push_back(e);
  endtask
  always @(posedge clk) begin
    #2;
    if (q.size() > 0) begin
      exp_t e;
      logic [31:0] ei;
      e = q.pop_front();
      ei = e.v ? e.ifpc * 32'h0001_0001 : 32'h0000_0013;
      chk("imem_addr", imem_addr, e.addr);
      chk("if_id_pc", if_id_pc, e.ifpc);
      chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.v});
      chk("if_id_instr", if_id_instr, ei);
      chk("if_id_Rs", {27'b0, if_id_Rs}, e.v ? {27'b0, ei[19:15]} : 32'b0);
      chk("if_id_Rt", {27'b0, if_id_Rt}, e.v ? {27'b0, ei[24:20]} : 32'b0);
      chk("stall_count", {28'b0, stall_count}, {28'b0, e.sc});
      chk("flush_count", {28'b0, flush_count}, {28'b0, e.fc});
    end
  end
  initial begin
    step(0, 0, 0, 32'h0,   32'h0,  32'h0,  0, 0, 0);
    step(0, 1, 1, 32'h80,  32'h0,  32'h0,  0, 0, 0);
    step(1, 0, 0, 32'h0,   32'h4,  32'h0,  1, 0, 0);
    step(1, 0, 0, 32'h0,   32'h8,  32'h4,  1, 0, 0);
    step(1, 0, 0, 32'h0,   32'hC,  32'h8,  1, 0, 0);
    step(1, 0, 0, 32'h0,   32'h10, 32'hC,  1, 0, 0);
    step(1, 1, 0, 32'h0,   32'h10, 32'hC,  1, 1, 0);
    step(1, 1, 0, 32'h0,   32'h10, 32'hC,  1, 2, 0);
    step(1, 0, 0, 32'h0,   32'h14, 32'h10, 1, 2, 0);
    step(1, 0, 0, 32'h0,   32'h18, 32'h14, 1, 2, 0);
    step(1, 0, 0, 32'h0,   32'h1C, 32'h18, 1, 2, 0);
    step(1, 0, 0, 32'h0,   32'h20, 32'h1C, 1, 2, 0);
    step(1, 0, 1, 32'h203, 32'h200, 32'h0, 0, 2, 1);
    step(1, 0, 0, 32'h0,   32'h204, 32'h200, 1, 2, 1);
    step(1, 1, 1, 32'h40,  32'h40, 32'h0,  0, 2, 2);
    step(1, 0, 0, 32'h0,   32'h44, 32'h40, 1, 2, 2);
    step(1, 0, 1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'h0, 0, 2, 3);
    step(1, 0, 0, 32'h0,   32'hFFFF_FFFC, 32'hFFFF_FFF8, 1, 2, 3);
    step(1, 0, 0, 32'h0,   32'h0,  32'hFFFF_FFFC, 1, 2, 3);
    step(1, 0, 0, 32'h0,   32'h4,  32'h0,  1, 2, 3);
    for (int i = 1; i <= 20; i++)
      step(1, 1, 0, 32'h0, 32'h4, 32'h0, 1, (2 + i > 15) ? 4'd15 : 4'(2 + i), 3);
    step(1, 0, 0, 32'h0,   32'h8,  32'h4,  1, 15, 3);
    step(1, 1, 0, 32'h0,   32'h8,  32'h4,  1, 15, 3);
    step(0, 1, 0, 32'h0,   32'h0,  32'h0,  0, 0, 0);
    step(1, 1, 0, 32'h0,   32'h0,  32'h0,  0, 1, 0);
    step(1, 0, 0, 32'h0,   32'h4,  32'h0,  1, 1, 0);
    @(posedge clk);
    #5;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
